// File: rtl/float_mul_requester.sv
// Initiator side of the float unit four-phase req/ack handshake: takes operand
// pairs from a valid/ready command port and returns each product (or abort) downstream.
module float_mul_requester #(
    parameter int float_width    = 32,
    parameter int timeout_cycles = 35,
    parameter int count_width    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [float_width-1:0] cmd_a,
    input  logic [float_width-1:0] cmd_b,
    output logic                   mul_req,
    input  logic                   mul_ack,
    output logic [float_width-1:0] mul_a,
    output logic [float_width-1:0] mul_b,
    input  logic [float_width-1:0] mul_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [float_width-1:0] res_out,
    output logic                   res_timeout,
    output logic [count_width-1:0] op_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam int                    cnt_width = $clog2(timeout_cycles + 1);
    localparam logic [cnt_width-1:0]  cnt_last  = cnt_width'(timeout_cycles - 1);

    logic [1:0]           state;
    logic [cnt_width-1:0] wait_cnt;

    // Gating with rst keeps the upstream port closed for the whole reset period.
    assign cmd_ready = rst && (state == IDLE);
    assign res_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mul_req     <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            res_out     <= '0;
            res_timeout <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mul_a    <= cmd_a;
                        mul_b    <= cmd_b;
                        mul_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                end
                // An ack in the final wait cycle is checked first, so it beats the timeout.
                REQ: begin
                    if (mul_ack) begin
                        res_out     <= mul_out;
                        res_timeout <= 1'b0;
                        mul_req     <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= RELEASE;
                    end else if (wait_cnt == cnt_last) begin
                        res_out     <= '0;
                        res_timeout <= 1'b1;
                        mul_req     <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!mul_ack) begin
                        state <= RESP;
                    end else if (wait_cnt == cnt_last) begin
                        res_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        if (!res_timeout) begin
                            op_count <= op_count + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
